lzw_backward_reverse_arb: RTL and testbench

LZW_BACKWARD_REVERSE_ARB -- requirements
Module: lzw_backward_reverse_arb

---
 rtl/lzw_backward_reverse_arb.sv | 180 ++++++++++++++++++
 tb/tb_lzw_backward_reverse_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzw_backward_reverse_arb.sv
// Two-lane segment arbiter feeding the LZW backward reverse block.
// Optional statistics counters are built only when LZW_REV_STAT_EN is defined.
module lzw_backward_reverse_arb #(
  parameter bit AFULL_HOLD = 1'b1
) (
  input  logic        I_sys_clk,
  input  logic        I_sys_rst_n,
  input  logic        I_state_clr,
  input  logic [1:0]  I_hdr_valid,
  input  logic [4:0]  I_hdr_len0,
  input  logic [4:0]  I_hdr_len1,
  input  logic [1:0]  I_hdr_rev,
  output logic [1:0]  O_hdr_ready,
  input  logic [7:0]  I_data0,
  input  logic [7:0]  I_data1,
  input  logic [1:0]  I_data_valid,
  output logic [1:0]  O_data_ready,
  input  logic        I_fifo_afull,
  output logic [7:0]  O_dictionary_recv_data,
  output logic        O_dictionary_recv_data_en,
  output logic        O_reverse_byte_flag,
  output logic [4:0]  O_reverse_byte_num,
  output logic        O_reverse_byte_num_wren,
  output logic [15:0] O_seg_cnt,
  output logic [31:0] O_byte_cnt
);

  typedef enum logic [1:0] {StIdle, StHdr, StData, StFlush} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        prio_q, prio_d;
  logic        rev_q, rev_d;
  logic [4:0]  cnt_q, cnt_d;

  logic [7:0]  data_q, data_d;
  logic        data_en_q, data_en_d;
  logic        flag_q, flag_d;
  logic [4:0]  num_q, num_d;
  logic        num_wren_q, num_wren_d;

  logic        hold;
  logic [4:0]  sel_len;
  logic        sel_rev;
  logic        sel_valid;
  logic [7:0]  sel_data;
  logic [1:0]  grant_onehot;
  logic        byte_acc;
  logic        seg_done;

  assign hold         = I_fifo_afull & AFULL_HOLD;
  assign sel_len      = grant_q ? I_hdr_len1 : I_hdr_len0;
  assign sel_rev      = I_hdr_rev[grant_q];
  assign sel_valid    = I_data_valid[grant_q];
  assign sel_data     = grant_q ? I_data1 : I_data0;
  assign grant_onehot = grant_q ? 2'b10 : 2'b01;

  assign byte_acc = (state_q == StData) & ~hold & sel_valid;
  assign seg_done = byte_acc & (cnt_q == 5'd1);

  always_comb begin
    O_hdr_ready  = 2'b00;
    O_data_ready = 2'b00;
    if (state_q == StHdr) begin
      O_hdr_ready = grant_onehot;
    end
    if (state_q == StData && !hold) begin
      O_data_ready = grant_onehot;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    rev_d   = rev_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (I_hdr_valid != 2'b00) begin
          // Round-robin only matters when both lanes are waiting.
          grant_d = (I_hdr_valid == 2'b11) ? prio_q : I_hdr_valid[1];
          state_d = StHdr;
        end
      end
      StHdr: begin
        rev_d   = sel_rev;
        cnt_d   = sel_len;
        prio_d  = ~grant_q;
        state_d = (sel_len == 5'd0) ? StIdle : StData;
      end
      StData: begin
        if (byte_acc) begin
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            state_d = StFlush;
          end
        end
      end
      StFlush: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    data_en_d  = byte_acc;
    data_d     = byte_acc ? sel_data : data_q;
    flag_d     = byte_acc ? rev_q : flag_q;
    num_wren_d = (state_q == StHdr) & sel_rev & (sel_len != 5'd0);
    num_d      = num_wren_d ? sel_len : num_q;
  end

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state_q    <= StIdle;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      rev_q      <= 1'b0;
      cnt_q      <= 5'd0;
      data_q     <= 8'd0;
      data_en_q  <= 1'b0;
      flag_q     <= 1'b0;
      num_q      <= 5'd0;
      num_wren_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      rev_q      <= rev_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      data_en_q  <= data_en_d;
      flag_q     <= flag_d;
      num_q      <= num_d;
      num_wren_q <= num_wren_d;
    end
  end

  assign O_dictionary_recv_data    = data_q;
  assign O_dictionary_recv_data_en = data_en_q;
  assign O_reverse_byte_flag       = flag_q;
  assign O_reverse_byte_num        = num_q;
  assign O_reverse_byte_num_wren   = num_wren_q;

`ifdef LZW_REV_STAT_EN
  logic [15:0] seg_cnt_q;
  logic [31:0] byte_cnt_q;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      seg_cnt_q  <= 16'd0;
      byte_cnt_q <= 32'd0;
    end else if (I_state_clr) begin
      seg_cnt_q  <= 16'd0;
      byte_cnt_q <= 32'd0;
    end else begin
      if (seg_done) begin
        seg_cnt_q <= seg_cnt_q + 16'd1;
      end
      if (byte_acc) begin
        byte_cnt_q <= byte_cnt_q + 32'd1;
      end
    end
  end

  assign O_seg_cnt  = seg_cnt_q;
  assign O_byte_cnt = byte_cnt_q;
`else
  logic unused_stat;
  assign unused_stat = I_state_clr ^ seg_done;
  assign O_seg_cnt   = 16'd0;
  assign O_byte_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_lzw_backward_reverse_arb.sv
// Scoreboard bench for lzw_backward_reverse_arb: expected bytes/num writes are queued
// at header handshake and checked as the outputs strobe.
module tb_lzw_backward_reverse_arb;

  logic        I_sys_clk = 1'b0;
  logic        I_sys_rst_n;
  logic        I_state_clr;
  logic [1:0]  I_hdr_valid;
  logic [4:0]  I_hdr_len0, I_hdr_len1;
  logic [1:0]  I_hdr_rev;
  logic [1:0]  O_hdr_ready;
  logic [7:0]  I_data0, I_data1;
  logic [1:0]  I_data_valid;
  logic [1:0]  O_data_ready;
  logic        I_fifo_afull;
  logic [7:0]  O_dictionary_recv_data;
  logic        O_dictionary_recv_data_en;
  logic        O_reverse_byte_flag;
  logic [4:0]  O_reverse_byte_num;
  logic        O_reverse_byte_num_wren;
  logic [15:0] O_seg_cnt;
  logic [31:0] O_byte_cnt;

  always #5 I_sys_clk = ~I_sys_clk;

  lzw_backward_reverse_arb #(.AFULL_HOLD(1'b1)) dut (
    .I_sys_clk                 (I_sys_clk),
    .I_sys_rst_n               (I_sys_rst_n),
    .I_state_clr               (I_state_clr),
    .I_hdr_valid               (I_hdr_valid),
    .I_hdr_len0                (I_hdr_len0),
    .I_hdr_len1                (I_hdr_len1),
    .I_hdr_rev                 (I_hdr_rev),
    .O_hdr_ready               (O_hdr_ready),
    .I_data0                   (I_data0),
    .I_data1                   (I_data1),
    .I_data_valid              (I_data_valid),
    .O_data_ready              (O_data_ready),
    .I_fifo_afull              (I_fifo_afull),
    .O_dictionary_recv_data    (O_dictionary_recv_data),
    .O_dictionary_recv_data_en (O_dictionary_recv_data_en),
    .O_reverse_byte_flag       (O_reverse_byte_flag),
    .O_reverse_byte_num        (O_reverse_byte_num),
    .O_reverse_byte_num_wren   (O_reverse_byte_num_wren),
    .O_seg_cnt                 (O_seg_cnt),
    .O_byte_cnt                (O_byte_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] data_exp_q[$];
  logic [4:0] num_exp_q[$];
  int         served_q[$];
  int         exp_seg, exp_byte;
  int         hdr_pulses, data_seen, num_seen;
  logic [8:0] mon_data;
  logic [4:0] mon_num;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge I_sys_clk) begin
    if (I_sys_rst_n) begin
      if (O_hdr_ready != 2'b00) begin
        hdr_pulses++;
        check_eq("hdr_onehot", $countones(O_hdr_ready), 1);
      end
      if (O_dictionary_recv_data_en) begin
        data_seen++;
        if (data_exp_q.size() == 0) begin
          check_eq("unexpected_data_en", 1, 0);
        end else begin
          mon_data = data_exp_q.pop_front();
          check_eq("data_flag", {O_reverse_byte_flag, O_dictionary_recv_data}, mon_data);
        end
      end
      if (O_reverse_byte_num_wren) begin
        num_seen++;
        if (num_exp_q.size() == 0) begin
          check_eq("unexpected_num_wren", 1, 0);
        end else begin
          mon_num = num_exp_q.pop_front();
          check_eq("rev_num", O_reverse_byte_num, mon_num);
        end
      end
    end
  end

  task automatic check_stats(input string tag);
`ifdef LZW_REV_STAT_EN
    check_eq({tag, "_seg"}, O_seg_cnt, exp_seg);
    check_eq({tag, "_byte"}, O_byte_cnt, exp_byte);
`else
    check_eq({tag, "_seg"}, O_seg_cnt, 0);
    check_eq({tag, "_byte"}, O_byte_cnt, 0);
`endif
  endtask

  // Asserts reset asynchronously, checks outputs drop at once, then releases.
  task automatic do_reset();
    I_sys_rst_n = 1'b0;
    I_hdr_valid  = 2'b00;
    I_data_valid = 2'b00;
    #1;
    check_eq("rst_data_en", O_dictionary_recv_data_en, 0);
    check_eq("rst_data", O_dictionary_recv_data, 0);
    check_eq("rst_num_wren", O_reverse_byte_num_wren, 0);
    check_eq("rst_hdr_ready", O_hdr_ready, 0);
    check_eq("rst_data_ready", O_data_ready, 0);
    check_eq("rst_seg_cnt", O_seg_cnt, 0);
    check_eq("rst_byte_cnt", O_byte_cnt, 0);
    data_exp_q.delete();
    num_exp_q.delete();
    exp_seg  = 0;
    exp_byte = 0;
    repeat (2) @(posedge I_sys_clk);
    #3;
    I_sys_rst_n = 1'b1;
  endtask

  task automatic send_seg(input int lane, input logic [4:0] len, input bit rev,
                          input logic [7:0] base, input int stop_after, output int n_acc);
    int budget;
    n_acc = 0;
    @(posedge I_sys_clk);
    #1;
    I_hdr_valid[lane] = 1'b1;
    I_hdr_rev[lane]   = rev;
    if (lane == 0) I_hdr_len0 = len;
    else           I_hdr_len1 = len;
    budget = 0;
    while (budget < 200) begin
      @(negedge I_sys_clk);
      if (O_hdr_ready[lane]) break;
      budget++;
    end
    if (budget >= 200) begin
      check_eq("hdr_timeout", 0, 1);
      I_hdr_valid[lane] = 1'b0;
      return;
    end
    @(posedge I_sys_clk);
    served_q.push_back(lane);
    if (rev && len != 5'd0) num_exp_q.push_back(len);
    for (int i = 0; i < int'(len); i++) data_exp_q.push_back({rev, base + 8'(i)});
    #1;
    I_hdr_valid[lane] = 1'b0;
    budget = 0;
    while (n_acc < int'(len) && n_acc != stop_after && budget < 400) begin
      I_data_valid[lane] = 1'b1;
      if (lane == 0) I_data0 = base + 8'(n_acc);
      else           I_data1 = base + 8'(n_acc);
      @(negedge I_sys_clk);
      if (O_data_ready[lane]) begin
        @(posedge I_sys_clk);
        n_acc++;
        exp_byte++;
      end else begin
        @(posedge I_sys_clk);
        budget++;
      end
      #1;
    end
    I_data_valid[lane] = 1'b0;
    if (budget >= 400) check_eq("data_timeout", n_acc, len);
    if (n_acc == int'(len) && len != 5'd0) exp_seg++;
  endtask

  int na, nb, p_hdr, p_data, p_num;

  initial begin
    I_sys_rst_n  = 1'b0;
    I_state_clr  = 1'b0;
    I_hdr_valid  = 2'b00;
    I_hdr_len0   = 5'd0;
    I_hdr_len1   = 5'd0;
    I_hdr_rev    = 2'b00;
    I_data0      = 8'd0;
    I_data1      = 8'd0;
    I_data_valid = 2'b00;
    I_fifo_afull = 1'b0;
    hdr_pulses = 0;
    data_seen  = 0;
    num_seen   = 0;
    do_reset();

    // Lane0, len 4, reversed: one num write and four flagged bytes in order.
    p_data = data_seen;
    p_num  = num_seen;
    send_seg(0, 5'd4, 1'b1, 8'h11, -1, na);
    repeat (3) @(posedge I_sys_clk);
    check_eq("t1_accepted", na, 4);
    check_eq("t1_data_cnt", data_seen - p_data, 4);
    check_eq("t1_num_cnt", num_seen - p_num, 1);
    check_stats("t1_stats");

    // Both lanes together after reset: 0,1 then 0,1 again.
    do_reset();
    served_q.delete();
    fork
      send_seg(0, 5'd3, 1'b0, 8'h20, -1, na);
      send_seg(1, 5'd2, 1'b1, 8'h30, -1, nb);
    join
    fork
      send_seg(0, 5'd2, 1'b1, 8'h50, -1, na);
      send_seg(1, 5'd3, 1'b0, 8'h60, -1, nb);
    join
    repeat (3) @(posedge I_sys_clk);
    check_eq("rr_count", served_q.size(), 4);
    if (served_q.size() == 4) begin
      check_eq("rr_0", served_q[0], 0);
      check_eq("rr_1", served_q[1], 1);
      check_eq("rr_2", served_q[2], 0);
      check_eq("rr_3", served_q[3], 1);
    end
    check_stats("rr_stats");

    // Zero-length header: one ready pulse, nothing else.
    p_hdr  = hdr_pulses;
    p_data = data_seen;
    p_num  = num_seen;
    send_seg(1, 5'd0, 1'b1, 8'h00, -1, na);
    repeat (4) @(posedge I_sys_clk);
    check_eq("len0_hdr_pulses", hdr_pulses - p_hdr, 1);
    check_eq("len0_data", data_seen - p_data, 0);
    check_eq("len0_num", num_seen - p_num, 0);
    check_stats("len0_stats");

    // Len 31 with a 5-cycle almost-full stall mid-segment.
    p_data = data_seen;
    p_num  = num_seen;
    fork
      send_seg(0, 5'd31, 1'b0, 8'h80, -1, na);
      begin
        repeat (12) @(posedge I_sys_clk);
        #1;
        I_fifo_afull = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge I_sys_clk);
          check_eq("stall_ready", O_data_ready, 0);
          if (k > 0) check_eq("stall_data_en", O_dictionary_recv_data_en, 0);
        end
        @(posedge I_sys_clk);
        #1;
        I_fifo_afull = 1'b0;
      end
    join
    repeat (3) @(posedge I_sys_clk);
    check_eq("long_accepted", na, 31);
    check_eq("long_data_cnt", data_seen - p_data, 31);
    check_eq("long_num_cnt", num_seen - p_num, 0);
    check_stats("long_stats");

    // Serve lane0 to move priority, then reset during byte 3 of len 8.
    send_seg(0, 5'd8, 1'b1, 8'hA0, 3, na);
    check_eq("abort_accepted", na, 3);
    do_reset();
    repeat (3) @(posedge I_sys_clk);
    served_q.delete();
    fork
      send_seg(0, 5'd2, 1'b0, 8'hC0, -1, na);
      send_seg(1, 5'd2, 1'b0, 8'hD0, -1, nb);
    join
    repeat (3) @(posedge I_sys_clk);
    check_eq("post_rst_count", served_q.size(), 2);
    if (served_q.size() == 2) begin
      check_eq("post_rst_first", served_q[0], 0);
      check_eq("post_rst_second", served_q[1], 1);
    end

    // Statistics: three 5-byte segments from a cleared state, then a clear.
    @(posedge I_sys_clk);
    #1;
    I_state_clr = 1'b1;
    @(posedge I_sys_clk);
    #1;
    I_state_clr = 1'b0;
    exp_seg  = 0;
    exp_byte = 0;
    for (int s = 0; s < 3; s++) send_seg(s % 2, 5'd5, s[0], 8'(8'hE0 + 8'(s * 8)), -1, na);
    repeat (3) @(posedge I_sys_clk);
`ifdef LZW_REV_STAT_EN
    check_eq("stat_seg3", O_seg_cnt, 3);
    check_eq("stat_byte15", O_byte_cnt, 15);
`endif
    check_stats("stat_model");
    #1;
    I_state_clr = 1'b1;
    @(posedge I_sys_clk);
    #1;
    I_state_clr = 1'b0;
    exp_seg  = 0;
    exp_byte = 0;
    @(negedge I_sys_clk);
    check_stats("stat_clr");

    repeat (4) @(posedge I_sys_clk);
    check_eq("data_q_empty", data_exp_q.size(), 0);
    check_eq("num_q_empty", num_exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
